dp_ram_sync: RTL and testbench

- Simple dual-port synchronous RAM used as the one-row line buffer of the integral-image generator.
- Port A is write-only; port B is read-only with a read enable.
- The generator writes the integral pixel of the current row on port A and reads the pixel directly above it (the previous row) on port B.
- Single clock domain; inferable as block RAM.

---
 rtl/dp_ram_sync.sv | 43 ++++
 tb/tb_dp_ram_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dp_ram_sync.sv
// Simple dual-port synchronous RAM: write-only port A, read-only port B with
// registered output. Serves as the one-row line buffer of the integral-image generator.
module dp_ram_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addra,
  input  logic              wea,
  input  logic [DATA_W-1:0] dina,
  input  logic [ADDR_W-1:0] addrb,
  input  logic              enb,
  output logic [DATA_W-1:0] doutb
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_doutb;
  logic              w_wr_p0;

  // A write arriving together with reset is dropped; stored words are never cleared.
  assign w_wr_p0 = wea & ~rst;

  always_ff @(posedge clk) begin
    if (w_wr_p0) begin
      r_mem[addra] <= dina;
    end
  end

  // Output register: the old word is sampled on a same-address collision (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_doutb <= '0;
    end else if (enb) begin
      r_doutb <= r_mem[addrb];
    end
  end

  assign doutb = r_doutb;

endmodule

// File: tb/tb_dp_ram_sync.sv
// Self-checking bench for dp_ram_sync: directed scenarios plus randomized traffic
// compared every cycle against an array-based model of the RAM.
module tb_dp_ram_sync;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] addra = '0;
  logic              wea = 1'b0;
  logic [DATA_W-1:0] dina = '0;
  logic [ADDR_W-1:0] addrb = '0;
  logic              enb = 1'b0;
  logic [DATA_W-1:0] doutb;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit                m_known [DEPTH];
  logic [DATA_W-1:0] exp_q     = '0;
  bit                exp_known = 1'b0;

  dp_ram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .addra (addra),
    .wea   (wea),
    .dina  (dina),
    .addrb (addrb),
    .enb   (enb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  // Per-cycle comparison whenever the model knows what doutb must be.
  always @(negedge clk) begin
    if (exp_known) begin
      total++;
      if (doutb !== exp_q) begin
        bad++;
        $display("FAIL model t=%0t doutb=%h expected=%h", $time, doutb, exp_q);
      end
    end
  end

  // Drive one cycle; model computes the post-edge doutb from pre-edge memory.
  task automatic cyc(input bit r, input bit we, input logic [ADDR_W-1:0] aa,
                     input logic [DATA_W-1:0] da, input bit re,
                     input logic [ADDR_W-1:0] ab);
    logic [DATA_W-1:0] nxt;
    bit                nk;
    rst = r; wea = we; addra = aa; dina = da; enb = re; addrb = ab;
    nxt = exp_q;
    nk  = exp_known;
    if (r) begin
      nxt = '0;
      nk  = 1'b1;
    end else begin
      if (re) begin
        nxt = m_mem[ab];
        nk  = m_known[ab];
      end
      if (we) begin
        m_mem[aa]   = da;
        m_known[aa] = 1'b1;
      end
    end
    @(posedge clk);
    exp_q     = nxt;
    exp_known = nk;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] v);
    total++;
    if (doutb !== v) begin
      bad++;
      $display("FAIL %s doutb=%h expected=%h", name, doutb, v);
    end
  endtask

  task automatic chk_not(input string name, input logic [DATA_W-1:0] v);
    total++;
    if (doutb === v) begin
      bad++;
      $display("FAIL %s doutb=%h must differ from %h", name, doutb, v);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end

    // Reset with a write pending: write must be suppressed.
    cyc(1, 1, 10'd5, 32'hAAAA, 0, 10'd0);
    chk("reset_c1", 32'h0);
    cyc(1, 1, 10'd5, 32'hAAAA, 0, 10'd0);
    chk("reset_c2", 32'h0);
    cyc(0, 0, 10'd0, 32'h0, 0, 10'd0);
    chk("after_reset", 32'h0);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd5);
    chk_not("reset_write_suppressed", 32'hAAAA);

    // Basic write then read.
    cyc(0, 1, 10'd0, 32'h11, 0, 10'd0);
    cyc(0, 1, 10'd1, 32'h22, 0, 10'd0);
    cyc(0, 1, 10'd2, 32'h33, 0, 10'd0);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd0);
    chk("basic_rd0", 32'h11);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd1);
    chk("basic_rd1", 32'h22);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd2);
    chk("basic_rd2", 32'h33);

    // Read-first collision.
    cyc(0, 1, 10'd7, 32'h100, 0, 10'd0);
    cyc(0, 1, 10'd7, 32'h200, 1, 10'd7);
    chk("collision_old", 32'h100);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd7);
    chk("collision_new", 32'h200);

    // Read-enable hold.
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd1);
    chk("hold_rd1", 32'h22);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 10'd0, 32'h0, 0, 10'd2);
      chk("hold_enb0", 32'h22);
    end
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd2);
    chk("hold_release", 32'h33);

    // Line-buffer streaming: row 0 then row 1 read-while-writing one behind.
    for (int i = 0; i < 640; i++) cyc(0, 1, 10'(i), 32'(i + 1), 0, 10'd0);
    for (int i = 0; i < 640; i++) begin
      cyc(0, (i > 0), 10'(i - 1), 32'(1000 + i), 1, 10'(i));
      chk("stream", 32'(i + 1));
    end

    // Max-address wrap.
    cyc(0, 1, 10'd1023, 32'hFFFF_FFFF, 0, 10'd0);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd1023);
    chk("max_addr", 32'hFFFF_FFFF);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd0);
    chk("addr0_intact", 32'd1001);

    // Randomized traffic on a narrow address window to force collisions,
    // with occasional reset pulses that must preserve memory.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
          10'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1),
          10'($urandom_range(0, 31)));
    end

    // Memory must survive the random resets.
    cyc(1, 0, 10'd0, 32'h0, 0, 10'd0);
    chk("final_reset", 32'h0);
    cyc(0, 0, 10'd0, 32'h0, 1, 10'd1023);
    chk("final_max_addr", 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
